// File: rtl/seq_mult16_if.sv
// Request/response bundle for the iterative multiplier: start with operands in, busy/done/product out.
interface seq_mult16_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     inA;
    logic [WIDTH-1:0]     inB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, inA, inB, input busy, done, product);
    modport slave  (input start, inA, inB, output busy, done, product);
endinterface

// File: rtl/seq_mult16.sv
// Iterative shift-and-add multiplier; one CLA-chain partial-product add per cycle.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (adds a one-cycle FIX sign-correction state).
module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    seq_mult16_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; product holds last result
    // RUN   | one add/shift step per cycle while count runs down to 1
    // FIX   | sign correction of the magnitude product (signed build only)
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Ripple of carry-lookahead slices; returns {carry_out, sum}.
    function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin);
        logic [WIDTH-1:0] s;
        logic [4:0]       slice;
        logic             c;
        c = cin;
        s = '0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            slice      = cla4(a[4*i +: 4], b[4*i +: 4], c);
            s[4*i +: 4] = slice[3:0];
            c          = slice[4];
        end
        return {c, s};
    endfunction

    state_t               state_q, state_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     upper;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    always_comb begin
        upper    = acc_q[2*WIDTH-1:WIDTH];
        step_sum = acc_q[0] ? cla_add(upper, mcand_q, 1'b0) : {1'b0, upper};
        shifted  = {1'b0, step_sum, acc_q[WIDTH-1:1]};
    end

`ifdef SEQ_MULT_SIGNED_EN
    logic             neg_q, neg_d;
    logic [WIDTH:0]   neg_a;
    logic [WIDTH:0]   neg_b;

    // Magnitudes via the same adder chain: invert and add one.
    always_comb begin
        neg_a = cla_add(~bus.inA, '0, 1'b1);
        neg_b = cla_add(~bus.inB, '0, 1'b1);
        a_mag = bus.inA[WIDTH-1] ? neg_a[WIDTH-1:0] : bus.inA;
        b_mag = bus.inB[WIDTH-1] ? neg_b[WIDTH-1:0] : bus.inB;
    end
`else
    always_comb begin
        a_mag = bus.inA;
        b_mag = bus.inB;
    end
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = a_mag;
                    acc_d   = {1'b0, {WIDTH{1'b0}}, b_mag};
                    count_d = CNT_W'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d   = bus.inA[WIDTH-1] ^ bus.inB[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = shifted;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                    state_d   = FIX;
`else
                    product_d = shifted[2*WIDTH-1:0];
                    state_d   = DONE;
`endif
                end
            end
`ifdef SEQ_MULT_SIGNED_EN
            FIX: begin
                product_d = neg_q ? (~acc_q[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_q[2*WIDTH-1:0];
                state_d   = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.busy    = (state_q == RUN) || (state_q == FIX);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Scoreboard bench for seq_mult16: expected products queued at start, checked on each done pulse.
module tb_seq_mult16;
    localparam int W = 16;
`ifdef SEQ_MULT_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;
    exp_t sb[$];

    seq_mult16_if #(.WIDTH(W)) bus ();

    seq_mult16 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [2*W-1:0] xa;
        logic signed [2*W-1:0] xb;
        xa = $signed({{W{a[W-1]}}, a});
        xb = $signed({{W{b[W-1]}}, b});
        return xa * xb;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("product", bus.product, e.prod);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start while the DUT is idle; returns in cycle 1 of the operation.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bus.start = 1'b1;
        bus.inA   = a;
        bus.inB   = b;
        e.prod    = model(a, b);
        e.due     = cyc + LAT;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    // Bounded wait for done; counts busy cycles seen from the current cycle on.
    task automatic finish_op(input string tag, input int exp_busy, input bit scramble);
        int nb = 0;
        bit seen = 1'b0;
        for (int k = 0; k < LAT + 4 && !seen; k++) begin
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) seen = 1'b1;
            if (scramble) begin
                bus.inA = W'($urandom);
                bus.inB = W'($urandom);
            end
            tick();
        end
        check({tag, "_busy_cycles"}, nb, exp_busy);
        check({tag, "_done_seen"}, seen, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.inA   = '0;
        bus.inB   = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_product", bus.product, 0);

        // 3*5 with per-cycle busy/done profile and hold afterwards
        start_op(16'd3, 16'd5);
        for (int k = 1; k <= LAT; k++) begin
            check($sformatf("t1_busy_c%0d", k), bus.busy, (k < LAT) ? 1 : 0);
            check($sformatf("t1_done_c%0d", k), bus.done, (k == LAT) ? 1 : 0);
            tick();
        end
        check("t1_product", bus.product, 32'h0000_000F);
        check("t1_done_low", bus.done, 0);
        repeat (3) tick();
        check("t1_hold", bus.product, 32'h0000_000F);

        start_op(16'hFFFF, 16'hFFFF);
        finish_op("ffff", LAT - 1, 1'b0);
`ifndef SEQ_MULT_SIGNED_EN
        check("ffff_product", bus.product, 32'hFFFE_0001);
`else
        check("ffff_product", bus.product, 32'h0000_0001);
`endif

        start_op(16'h1234, 16'h0000);
        finish_op("zero_b", LAT - 1, 1'b0);
        check("zero_b_product", bus.product, 0);
        start_op(16'h0000, 16'hBEEF);
        finish_op("zero_a", LAT - 1, 1'b0);
        check("zero_a_product", bus.product, 0);

        // start while busy and operand changes are ignored
        d0 = n_done;
        start_op(16'd7, 16'd9);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.inA   = 16'd2;
        bus.inB   = 16'd2;
        tick();
        bus.start = 1'b0;
        finish_op("overlap", LAT - 6, 1'b1);
        check("overlap_product", bus.product, 63);
        repeat (W + 4) tick();
        check("overlap_single_done", n_done - d0, 1);

        // reset mid-operation aborts with no done
        d0 = n_done;
        start_op(16'h00FF, 16'h0101);
        repeat (7) tick();
        rst = 1'b1;
        void'(sb.pop_back());
        tick();
        rst = 1'b0;
        check("abort_product", bus.product, 0);
        check("abort_busy", bus.busy, 0);
        repeat (W + 4) tick();
        check("abort_no_done", n_done - d0, 0);
        start_op(16'd2, 16'd6);
        finish_op("after_abort", LAT - 1, 1'b0);
        check("after_abort_product", bus.product, 12);

        // rst and start together: start dropped
        d0 = n_done;
        bus.start = 1'b1;
        bus.inA   = 16'd9;
        bus.inB   = 16'd9;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        check("rst_start_product", bus.product, 0);
        repeat (W + 4) tick();
        check("rst_start_no_done", n_done - d0, 0);

`ifdef SEQ_MULT_SIGNED_EN
        start_op(16'hFFFD, 16'd5);
        finish_op("neg3x5", LAT - 1, 1'b0);
        check("neg3x5_product", bus.product, 32'hFFFF_FFF1);
        start_op(16'h8000, 16'h8000);
        finish_op("minmin", LAT - 1, 1'b0);
        check("minmin_product", bus.product, 32'h4000_0000);
`endif

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            start_op(ra, rb);
            finish_op($sformatf("rand%0d", i), LAT - 1, 1'b0);
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
